// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: two age-ordered holding slots share one register-file write port.
// Define REGWB_FWD_EN to add the combinational forwarding lookup (FWD_ADDR/FWD_HIT/FWD_DATA).
module reg_wb_arbiter #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int INIT_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CLEAR,
    input  logic                 ALU_VALID,
    input  logic [ADDR_W-1:0]    ALU_ADDR,
    input  logic [DATA_W-1:0]    ALU_DATA,
    output logic                 ALU_READY,
    input  logic                 MEM_VALID,
    input  logic [ADDR_W-1:0]    MEM_ADDR,
    input  logic [DATA_W-1:0]    MEM_DATA,
    output logic                 MEM_READY,
    output logic                 WRITE,
    output logic [ADDR_W-1:0]    INADDRESS,
    output logic [DATA_W-1:0]    IN,
    output logic                 RF_RESET,
`ifdef REGWB_FWD_EN
    input  logic [ADDR_W-1:0]    FWD_ADDR,
    output logic                 FWD_HIT,
    output logic [DATA_W-1:0]    FWD_DATA,
`endif
    output logic [2**ADDR_W-1:0] BUSY
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               alu_v_q, alu_v_n, mem_v_q, mem_v_n;
    logic [ADDR_W-1:0]  alu_a_q, alu_a_n, mem_a_q, mem_a_n;
    logic [DATA_W-1:0]  alu_d_q, alu_d_n, mem_d_q, mem_d_n;
    logic               alu_old_q, alu_old_n;
    logic               write_n, rf_n;
    logic [ADDR_W-1:0]  inaddr_n;
    logic [DATA_W-1:0]  in_n;
    logic               alu_acc, mem_acc, g_alu, g_mem;
    logic               alu_keep, mem_keep;

    assign ALU_READY = (state_q == S_RUN) & ~alu_v_q;
    assign MEM_READY = (state_q == S_RUN) & ~mem_v_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            alu_v_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_d_q   <= '0;
            mem_v_q   <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            alu_old_q <= 1'b1;
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
            RF_RESET  <= 1'b1;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            alu_v_q   <= alu_v_n;
            alu_a_q   <= alu_a_n;
            alu_d_q   <= alu_d_n;
            mem_v_q   <= mem_v_n;
            mem_a_q   <= mem_a_n;
            mem_d_q   <= mem_d_n;
            alu_old_q <= alu_old_n;
            WRITE     <= write_n;
            INADDRESS <= inaddr_n;
            IN        <= in_n;
            RF_RESET  <= rf_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        alu_v_n   = alu_v_q;
        alu_a_n   = alu_a_q;
        alu_d_n   = alu_d_q;
        mem_v_n   = mem_v_q;
        mem_a_n   = mem_a_q;
        mem_d_n   = mem_d_q;
        alu_old_n = alu_old_q;
        write_n   = WRITE;
        inaddr_n  = INADDRESS;
        in_n      = IN;
        rf_n      = RF_RESET;
        alu_acc   = ALU_VALID & ALU_READY;
        mem_acc   = MEM_VALID & MEM_READY;
        g_alu     = 1'b0;
        g_mem     = 1'b0;
        alu_keep  = 1'b0;
        mem_keep  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                write_n = 1'b0;
                rf_n    = 1'b1;
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_n = S_RUN;
                    rf_n    = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                rf_n = 1'b0;
                if (CLEAR) begin
                    alu_v_n   = 1'b0;
                    mem_v_n   = 1'b0;
                    write_n   = 1'b0;
                    alu_old_n = 1'b1;
                end else begin
                    g_alu   = alu_v_q & (~mem_v_q | alu_old_q);
                    g_mem   = mem_v_q & ~g_alu;
                    write_n = g_alu | g_mem;
                    if (g_alu) begin
                        inaddr_n = alu_a_q;
                        in_n     = alu_d_q;
                    end else if (g_mem) begin
                        inaddr_n = mem_a_q;
                        in_n     = mem_d_q;
                    end
                    alu_keep = alu_v_q & ~g_alu;
                    mem_keep = mem_v_q & ~g_mem;
                    alu_v_n  = alu_keep | alu_acc;
                    mem_v_n  = mem_keep | mem_acc;
                    if (alu_acc) begin
                        alu_a_n = ALU_ADDR;
                        alu_d_n = ALU_DATA;
                    end
                    if (mem_acc) begin
                        mem_a_n = MEM_ADDR;
                        mem_d_n = MEM_DATA;
                    end
                    // A surviving slot is always older than a fresh accept
                    if (alu_keep && !mem_keep)
                        alu_old_n = 1'b1;
                    else if (mem_keep && !alu_keep)
                        alu_old_n = 1'b0;
                    else if (!alu_keep && !mem_keep)
                        alu_old_n = 1'b1;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

    always_comb begin
        BUSY = '0;
        if (alu_v_q)
            BUSY[alu_a_q] = 1'b1;
        if (mem_v_q)
            BUSY[mem_a_q] = 1'b1;
        if (WRITE)
            BUSY[INADDRESS] = 1'b1;
    end

`ifdef REGWB_FWD_EN
    logic              y_v, o_v;
    logic [ADDR_W-1:0] y_a, o_a;
    logic [DATA_W-1:0] y_d, o_d;

    always_comb begin
        y_v      = alu_old_q ? mem_v_q : alu_v_q;
        y_a      = alu_old_q ? mem_a_q : alu_a_q;
        y_d      = alu_old_q ? mem_d_q : alu_d_q;
        o_v      = alu_old_q ? alu_v_q : mem_v_q;
        o_a      = alu_old_q ? alu_a_q : mem_a_q;
        o_d      = alu_old_q ? alu_d_q : mem_d_q;
        FWD_HIT  = 1'b0;
        FWD_DATA = '0;
        if (y_v && y_a == FWD_ADDR) begin
            FWD_HIT  = 1'b1;
            FWD_DATA = y_d;
        end else if (o_v && o_a == FWD_ADDR) begin
            FWD_HIT  = 1'b1;
            FWD_DATA = o_d;
        end else if (WRITE && INADDRESS == FWD_ADDR) begin
            FWD_HIT  = 1'b1;
            FWD_DATA = IN;
        end
    end
`endif

endmodule
